// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - LFSR pattern checker: locks onto a received LFSR word stream and flags deviations
//
// Ports:
//   clk           - clock
//   reset         - asynchronous, active-high reset
//   in_valid      - in_data carries a sample this cycle
//   in_data       - received word
//   clear_counts  - synchronous clear of the error counters (wins over an increment)
//   locked        - checker is in LOCKED
//   error         - one-cycle pulse per mismatching sample while LOCKED
//   err_count     - saturating count of mismatching samples
//   bit_err_count - saturating count of mismatching bits (LFSR_CHECKER_BIT_ERR_EN), else 0
//
// Optional feature macro: LFSR_CHECKER_BIT_ERR_EN

module lfsr_checker #(
    parameter int              WIDTH         = 8,
    parameter logic [WIDTH-1:0] TAPS         = 'b11101,
    parameter bit              INVERT        = 1'b0,
    parameter int              LOCK_COUNT    = 4,
    parameter int              LOSS_COUNT    = 3,
    parameter int              ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     clear_counts,
    output logic                     locked,
    output logic                     error,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ERR_CNT_WIDTH-1:0] bit_err_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     pred, pred_n;
    logic                 have_pred, have_n;
    logic [MW-1:0]        match_cnt, match_n;
    logic [LW-1:0]        miss_cnt, miss_n;
    logic                 error_n;
    logic                 err_inc;

    // Same next-state function as the generator so both ends agree by construction.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], 1'b0} ^ ((x[WIDTH-1] ^ INVERT) ? TAPS : '0);
    endfunction

    always_comb begin
        state_n = state;
        pred_n  = pred;
        have_n  = have_pred;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        error_n = 1'b0;
        err_inc = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    // A fixed point of next() would predict itself forever; refuse to seed from it.
                    if (lfsr_next(in_data) == in_data) begin
                        match_n = '0;
                        have_n  = 1'b0;
                    end else begin
                        pred_n = lfsr_next(in_data);
                        have_n = 1'b1;
                        if (have_pred && in_data == pred) begin
                            if (match_cnt == LOCK_LAST) begin
                                state_n = LOCKED;
                                match_n = '0;
                                miss_n  = '0;
                            end else begin
                                match_n = match_cnt + 1'b1;
                            end
                        end else begin
                            match_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction runs free and is never reseeded from the input.
                    pred_n = lfsr_next(pred);
                    if (in_data == pred) begin
                        miss_n = '0;
                    end else begin
                        error_n = 1'b1;
                        err_inc = 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            state_n = HUNT;
                            match_n = '0;
                            have_n  = 1'b0;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            pred      <= '0;
            have_pred <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            have_pred <= have_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            error     <= error_n;
            if (clear_counts)
                err_count <= '0;
            else if (err_inc && err_count != CNT_MAX)
                err_count <= err_count + 1'b1;
        end
    end

    assign locked = (state == LOCKED);

`ifdef LFSR_CHECKER_BIT_ERR_EN
    // Wide enough that adding a full-word popcount to a saturated counter cannot wrap.
    localparam int SW = ERR_CNT_WIDTH + WIDTH;

    logic [SW-1:0] bit_pop;
    logic [SW-1:0] bit_sum;
    logic [WIDTH-1:0] bit_diff;

    always_comb begin
        bit_diff = in_data ^ pred;
        bit_pop  = '0;
        for (int i = 0; i < WIDTH; i++)
            bit_pop = bit_pop + SW'(bit_diff[i]);
        bit_sum = SW'(bit_err_count) + bit_pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_err_count <= '0;
        end else if (clear_counts) begin
            bit_err_count <= '0;
        end else if (in_valid && state == LOCKED) begin
            if (bit_sum > SW'(CNT_MAX))
                bit_err_count <= CNT_MAX;
            else
                bit_err_count <= bit_sum[ERR_CNT_WIDTH-1:0];
        end
    end
`else
    assign bit_err_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard testbench for lfsr_checker
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_BIT_ERR_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       clear_counts = 1'b0;
    logic       locked;
    logic       error;
    logic [1:0] err_count;
    logic [1:0] bit_err_count;

    int checks = 0;
    int passed = 0;
    logic [5:0] expq[$];
    logic v_d = 1'b0;

    lfsr_checker #(
        .WIDTH(8), .TAPS(8'h1D), .INVERT(1'b0),
        .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_CNT_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear_counts(clear_counts), .locked(locked), .error(error),
        .err_count(err_count), .bit_err_count(bit_err_count)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents a result the cycle after a valid sample or a clear.
    always @(posedge clk) v_d <= in_valid | clear_counts;

    always @(negedge clk) begin
        if (v_d && !reset) begin
            logic [5:0] e;
            logic [5:0] a;
            a = {locked, error, err_count, bit_err_count};
            checks++;
            if (expq.size() == 0) begin
                $display("FAIL scoreboard_underflow actual=%b required=<none>", a);
            end else begin
                e = expq.pop_front();
                if (a === e) passed++;
                else $display("FAIL sample %0d {locked,error,err,bit}: actual=%b required=%b", checks, a, e);
            end
        end
    end

    task automatic push(input logic l, input logic e, input logic [1:0] c, input logic [1:0] b);
        expq.push_back({l, e, c, BE ? b : 2'd0});
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic e,
                        input logic [1:0] c, input logic [1:0] b);
        in_valid = 1'b1;
        in_data  = d;
        push(l, e, c, b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_clr(input logic [7:0] d, input logic l, input logic e,
                            input logic [1:0] c, input logic [1:0] b);
        clear_counts = 1'b1;
        send(d, l, e, c, b);
        clear_counts = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic direct(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    // Asserted between edges; outputs must clear before the next clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        direct("async_locked", {1'b0, locked}, 2'd0);
        direct("async_err_count", err_count, 2'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lock_seq(input int gap);
        send(8'h01, 0, 0, 0, 0); idle(gap);
        send(8'h02, 0, 0, 0, 0); idle(gap);
        send(8'h04, 0, 0, 0, 0); idle(gap);
        send(8'h08, 0, 0, 0, 0); idle(gap);
        send(8'h10, 1, 0, 0, 0); idle(gap);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        direct("reset_locked", {1'b0, locked}, 2'd0);
        direct("reset_error", {1'b0, error}, 2'd0);
        direct("reset_err_count", err_count, 2'd0);
        direct("reset_bit_err", bit_err_count, 2'd0);
        reset = 1'b0;

        // Lock, then one wrong word.
        lock_seq(0);
        send(8'h20, 1, 0, 0, 0);
        send(8'h41, 1, 1, 1, 1);
        send(8'h80, 1, 0, 1, 1);
        send(8'h1D, 1, 0, 1, 1);
        send(8'h3A, 1, 0, 1, 1);

        // Clear alone, then loss of lock (pred 74,E8,CD).
        clear_counts = 1'b1; push(1, 0, 0, 0); @(negedge clk); clear_counts = 1'b0;
        send(8'h55, 1, 1, 1, 2);
        send(8'h55, 1, 1, 2, 3);
        send(8'h55, 0, 1, 3, 3);
        send(8'h01, 0, 0, 3, 3);
        send(8'h02, 0, 0, 3, 3);
        send(8'h04, 0, 0, 3, 3);
        send(8'h08, 0, 0, 3, 3);
        send(8'h10, 1, 0, 3, 3);

        // Stuck-at and alternating 00/01 streams never lock.
        async_reset();
        for (int i = 0; i < 20; i++) send(8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) send((i % 2) ? 8'h01 : 8'h00, 0, 0, 0, 0);

        // Gaps, saturation of a 2-bit counter, clear racing an increment.
        async_reset();
        lock_seq(1);
        send(8'hFF, 1, 1, 1, 3); idle(1);
        send(8'h40, 1, 0, 1, 3); idle(1);
        send(8'hFF, 1, 1, 2, 3); idle(1);
        send(8'h1D, 1, 0, 2, 3); idle(2);
        send(8'hFF, 1, 1, 3, 3);
        send(8'h74, 1, 0, 3, 3); idle(1);
        send(8'hFF, 1, 1, 3, 3);
        send(8'hCD, 1, 0, 3, 3); idle(3);
        send(8'hFF, 1, 1, 3, 3);
        send_clr(8'hFF, 1, 1, 0, 0);
        send(8'h26, 1, 0, 0, 0);
        send(8'hFF, 1, 1, 1, 3);

        // Asynchronous reset while locked; next sample is a fresh seed.
        async_reset();
        send(8'h02, 0, 0, 0, 0);
        send(8'h04, 0, 0, 0, 0);
        send(8'h08, 0, 0, 0, 0);
        send(8'h10, 0, 0, 0, 0);
        send(8'h20, 1, 0, 0, 0);

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        checks++;
        if (expq.size() == 0) passed++;
        else $display("FAIL scoreboard_drain actual=%0d pending required=0", expq.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
